brent_kung_sub_pipe: RTL and testbench

Pipelined 16-bit Brent-Kung subtractor, the inverse-direction companion of the team's Brent-Kung adder.
- Computes a - b as a + ~b + 1 using a Brent-Kung prefix carry tree split across three register stages.
- Accepts one operand pair per cycle under a valid/ready handshake; results leave through a matching valid/ready port.
- Used by the datapath where difference, borrow and compare flags are needed at full throughput.

---
 rtl/bk_pkg.sv | 23 ++
 rtl/brent_kung_sub_pipe_if.sv | 26 ++
 rtl/bk_gp_cell.sv | 10 +
 rtl/brent_kung_sub_pipe.sv | 181 ++++++++++++++++++
 tb/tb_brent_kung_sub_pipe.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/bk_pkg.sv
// Shared Brent-Kung prefix-tree types and helpers for the adder/subtractor family.
// gp_combine is the black-cell operator; grey cells reuse it and ignore p.
package bk_pkg;

  localparam int BK_WIDTH = 16;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  function automatic gp_t gp_combine(gp_t hi, gp_t lo);
    gp_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

  function automatic int bk_levels(int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/brent_kung_sub_pipe_if.sv
// Operand/result handshake bundle for brent_kung_sub_pipe.
// master = producer/consumer side, slave = the subtractor itself.
interface brent_kung_sub_pipe_if #(
  parameter int WIDTH = bk_pkg::BK_WIDTH
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] s;
  logic             borrow;
  logic             zero;
  logic             ovf;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output a, b, in_valid, out_ready,
    input  in_ready, s, borrow, zero, ovf, out_valid
  );

  modport slave (
    input  a, b, in_valid, out_ready,
    output in_ready, s, borrow, zero, ovf, out_valid
  );
endinterface

// File: rtl/bk_gp_cell.sv
// Brent-Kung black cell: merges a higher (g,p) group with the adjacent lower one.
module bk_gp_cell
  import bk_pkg::*;
(
  input  gp_t hi,
  input  gp_t lo,
  output gp_t gp_o
);
  assign gp_o = gp_combine(hi, lo);
endmodule

// File: rtl/brent_kung_sub_pipe.sv
// Three-stage pipelined Brent-Kung subtractor: s = a + ~b + 1 with borrow/zero/ovf flags.
// Stage 1 forms bitwise g/p, stage 2 runs the up-sweep, stage 3 the down-sweep and sum.
module brent_kung_sub_pipe
  import bk_pkg::*;
#(
  parameter int WIDTH = BK_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  brent_kung_sub_pipe_if.slave   bus
);

  localparam int LEVELS = bk_levels(WIDTH);

  function automatic logic sub_ovf(logic a_msb, logic b_msb, logic s_msb);
    return (a_msb ^ b_msb) & (a_msb ^ s_msb);
  endfunction

  logic vld_p1_q, vld_p1_d;
  logic vld_p2_q, vld_p2_d;
  logic vld_p3_q, vld_p3_d;
  logic adv1, adv2, adv3, in_rdy;

  logic [WIDTH-1:0] g_p1_q, g_p1_d;
  logic [WIDTH-1:0] p_p1_q, p_p1_d;
  logic             a_msb_p1_q, a_msb_p1_d;
  logic             b_msb_p1_q, b_msb_p1_d;

  gp_t              up_p2_q [WIDTH];
  gp_t              up_p2_d [WIDTH];
  logic [WIDTH-1:0] p_p2_q, p_p2_d;
  logic             a_msb_p2_q, a_msb_p2_d;
  logic             b_msb_p2_q, b_msb_p2_d;

  logic [WIDTH-1:0] s_p3_q, s_p3_d;
  logic             borrow_p3_q, borrow_p3_d;
  logic             zero_p3_q, zero_p3_d;
  logic             ovf_p3_q, ovf_p3_d;

  gp_t              up [LEVELS+1][WIDTH];
  gp_t              dn [LEVELS][WIDTH];
  logic [WIDTH:0]   c;

  // Each stage moves on when the stage after it is empty or moving itself.
  always_comb begin
    adv3     = ~vld_p3_q | bus.out_ready;
    adv2     = ~vld_p3_q | adv3;
    adv1     = ~vld_p2_q | adv2;
    in_rdy   = ~vld_p1_q | adv1;
    vld_p1_d = in_rdy ? bus.in_valid : vld_p1_q;
    vld_p2_d = adv1   ? vld_p1_q     : vld_p2_q;
    vld_p3_d = adv2   ? vld_p2_q     : vld_p3_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      vld_p3_q <= 1'b0;
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      vld_p3_q <= vld_p3_d;
    end
  end

  // ---- stage 1: bitwise generate/propagate of a + ~b ----
  always_comb begin
    g_p1_d     = g_p1_q;
    p_p1_d     = p_p1_q;
    a_msb_p1_d = a_msb_p1_q;
    b_msb_p1_d = b_msb_p1_q;
    if (in_rdy && bus.in_valid) begin
      g_p1_d     = bus.a & ~bus.b;
      p_p1_d     = bus.a ^ ~bus.b;
      a_msb_p1_d = bus.a[WIDTH-1];
      b_msb_p1_d = bus.b[WIDTH-1];
    end
  end

  // ---- stage 2: up-sweep; carry-in of 1 is absorbed into node 0 ----
  for (genvar i = 0; i < WIDTH; i++) begin : g_leaf
    if (i == 0) begin : g_cin
      assign up[0][i] = '{g: g_p1_q[i] | p_p1_q[i], p: p_p1_q[i]};
    end else begin : g_plain
      assign up[0][i] = '{g: g_p1_q[i], p: p_p1_q[i]};
    end
  end

  for (genvar l = 0; l < LEVELS; l++) begin : g_up_lvl
    localparam int STEP = 1 << l;
    for (genvar i = 0; i < WIDTH; i++) begin : g_up_node
      if (((i + 1) % (2 * STEP)) == 0) begin : g_cell
        bk_gp_cell u_cell (.hi(up[l][i]), .lo(up[l][i-STEP]), .gp_o(up[l+1][i]));
      end else begin : g_pass
        assign up[l+1][i] = up[l][i];
      end
    end
  end

  always_comb begin
    up_p2_d    = up_p2_q;
    p_p2_d     = p_p2_q;
    a_msb_p2_d = a_msb_p2_q;
    b_msb_p2_d = b_msb_p2_q;
    if (adv1 && vld_p1_q) begin
      up_p2_d    = up[LEVELS];
      p_p2_d     = p_p1_q;
      a_msb_p2_d = a_msb_p1_q;
      b_msb_p2_d = b_msb_p1_q;
    end
  end

  always_ff @(posedge clk) begin
    g_p1_q     <= g_p1_d;
    p_p1_q     <= p_p1_d;
    a_msb_p1_q <= a_msb_p1_d;
    b_msb_p1_q <= b_msb_p1_d;
    up_p2_q    <= up_p2_d;
    p_p2_q     <= p_p2_d;
    a_msb_p2_q <= a_msb_p2_d;
    b_msb_p2_q <= b_msb_p2_d;
  end

  // ---- stage 3: down-sweep fills the remaining prefixes, then sum and flags ----
  for (genvar i = 0; i < WIDTH; i++) begin : g_dn_seed
    assign dn[0][i] = up_p2_q[i];
  end

  for (genvar j = 0; j < LEVELS - 1; j++) begin : g_dn_lvl
    localparam int STEP = 1 << (LEVELS - 2 - j);
    for (genvar i = 0; i < WIDTH; i++) begin : g_dn_node
      if ((i >= 3 * STEP - 1) && (((i + 1 - STEP) % (2 * STEP)) == 0)) begin : g_cell
        bk_gp_cell u_cell (.hi(dn[j][i]), .lo(dn[j][i-STEP]), .gp_o(dn[j+1][i]));
      end else begin : g_pass
        assign dn[j+1][i] = dn[j][i];
      end
    end
  end

  assign c[0] = 1'b1;
  for (genvar i = 0; i < WIDTH; i++) begin : g_carry
    assign c[i+1] = dn[LEVELS-1][i].g;
  end

  // Group propagate over all bits is set exactly when a == b, i.e. the difference is zero.
  always_comb begin
    s_p3_d      = s_p3_q;
    borrow_p3_d = borrow_p3_q;
    zero_p3_d   = zero_p3_q;
    ovf_p3_d    = ovf_p3_q;
    if (adv2 && vld_p2_q) begin
      s_p3_d      = p_p2_q ^ c[WIDTH-1:0];
      borrow_p3_d = ~c[WIDTH];
      zero_p3_d   = dn[LEVELS-1][WIDTH-1].p;
      ovf_p3_d    = sub_ovf(a_msb_p2_q, b_msb_p2_q, s_p3_d[WIDTH-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_p3_q      <= '0;
      borrow_p3_q <= 1'b0;
      zero_p3_q   <= 1'b0;
      ovf_p3_q    <= 1'b0;
    end else begin
      s_p3_q      <= s_p3_d;
      borrow_p3_q <= borrow_p3_d;
      zero_p3_q   <= zero_p3_d;
      ovf_p3_q    <= ovf_p3_d;
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = vld_p3_q;
  assign bus.s         = s_p3_q;
  assign bus.borrow    = borrow_p3_q;
  assign bus.zero      = zero_p3_q;
  assign bus.ovf       = ovf_p3_q;

endmodule

// File: tb/tb_brent_kung_sub_pipe.sv
// Directed bench for brent_kung_sub_pipe: single ops, backpressure, mid-stream reset, range sweep.
module tb_brent_kung_sub_pipe;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  brent_kung_sub_pipe_if #(.WIDTH(16)) bus ();
  brent_kung_sub_pipe #(.WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(string tag, logic [15:0] a, logic [15:0] b,
                       logic [15:0] es, logic eb, logic ez, logic eo);
    bus.a = a; bus.b = b; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    #1;
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    check({tag, "_lat1"}, 32'(bus.out_valid), 32'd0);
    tick();
    check({tag, "_lat2"}, 32'(bus.out_valid), 32'd0);
    tick();
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_s"}, 32'(bus.s), 32'(es));
    check({tag, "_flags"}, {29'd0, bus.borrow, bus.zero, bus.ovf}, {29'd0, eb, ez, eo});
    tick();
    check({tag, "_one_cycle"}, 32'(bus.out_valid), 32'd0);
  endtask

  logic [15:0] bp_a [6] = '{16'd10, 16'd20, 16'd300, 16'd5, 16'hFFFF, 16'd1000};
  logic [15:0] bp_b [6] = '{16'd3,  16'd5,  16'd1,   16'd9, 16'd1,    16'd1000};
  logic [15:0] bp_s [6] = '{16'd7,  16'd15, 16'd299, 16'hFFFC, 16'hFFFE, 16'd0};
  logic        bp_w [6] = '{1'b0,   1'b0,   1'b0,    1'b1,  1'b0,     1'b0};
  logic [15:0] sw_a [4] = '{16'd0, 16'd2499, 16'd0,    16'd2499};
  logic [15:0] sw_b [4] = '{16'd0, 16'd2499, 16'd2499, 16'd0};

  typedef struct { logic [16:0] sum; logic z; logic o; } exp_t;
  exp_t sb [$];

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int idx, acc, got, cyc;
    exp_t e;
    logic signed [16:0] sd;

    rst = 1'b1; bus.a = '0; bus.b = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    tick(); tick();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_s", 32'(bus.s), 32'd0);
    check("rst_flags", {29'd0, bus.borrow, bus.zero, bus.ovf}, 32'd0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    do_op("basic",   16'd75,    16'd50,    16'd25,    1'b0, 1'b0, 1'b0);
    do_op("wrap",    16'd0,     16'd1,     16'hFFFF,  1'b1, 1'b0, 1'b0);
    do_op("equal",   16'h1234,  16'h1234,  16'h0000,  1'b0, 1'b1, 1'b0);
    do_op("ovf_neg", 16'h8000,  16'h0001,  16'h7FFF,  1'b0, 1'b0, 1'b1);
    do_op("ovf_pos", 16'h7FFF,  16'hFFFF,  16'h8000,  1'b1, 1'b0, 1'b1);

    // Backpressure: fill the pipe with the consumer stalled.
    idx = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.a = bp_a[idx]; bus.b = bp_b[idx];
      #1;
      if (bus.in_ready) idx++;
      @(posedge clk);
    end
    #1;
    check("bp_accepted", 32'(idx), 32'd3);
    check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
    check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
    check("bp_hold_s", 32'(bus.s), 32'(bp_s[0]));
    tick();
    check("bp_hold_s_later", 32'(bus.s), 32'(bp_s[0]));

    got = 0; cyc = 0;
    while (got < 6 && cyc < 40) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      bus.in_valid = (idx < 6);
      if (idx < 6) begin bus.a = bp_a[idx]; bus.b = bp_b[idx]; end
      #1;
      if (bus.out_valid) begin
        check("bp_drain_s", 32'(bus.s), 32'(bp_s[got]));
        check("bp_drain_borrow", 32'(bus.borrow), 32'(bp_w[got]));
        got++;
      end
      if (bus.in_valid && bus.in_ready) idx++;
      cyc++;
    end
    check("bp_drain_count", 32'(got), 32'd6);
    @(negedge clk); bus.in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("bp_no_dup", 32'(bus.out_valid), 32'd0);
    end

    // Reset with two operations in flight.
    bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.a = 16'd40; bus.b = 16'd2;
    tick();
    bus.a = 16'd50; bus.b = 16'd7;
    tick();
    rst = 1'b1; bus.a = 16'd9; bus.b = 16'd1;
    tick();
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_s", 32'(bus.s), 32'd0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    rst = 1'b0; bus.in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("mid_rst_no_stale", 32'(bus.out_valid), 32'd0);
    end

    // Range sweep with random handshakes against a plain arithmetic model.
    acc = 0; got = 0; cyc = 0;
    while (got < 400 && cyc < 6000) begin
      @(negedge clk);
      bus.in_valid  = (acc < 400) && ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if (acc < 4) begin
        bus.a = sw_a[acc]; bus.b = sw_b[acc];
      end else begin
        bus.a = 16'($urandom_range(0, 2499)); bus.b = 16'($urandom_range(0, 2499));
      end
      #1;
      if (bus.in_valid && bus.in_ready) begin
        e.sum = {1'b0, bus.a} + {1'b0, ~bus.b} + 17'd1;
        e.z   = (bus.a == bus.b);
        sd    = 17'($signed(bus.a)) - 17'($signed(bus.b));
        e.o   = (sd > 17'sd32767) || (sd < -17'sd32768);
        sb.push_back(e);
        acc++;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check("sweep_unexpected", 32'(bus.out_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          check("sweep_sum", 32'({~bus.borrow, bus.s}), 32'(e.sum));
          check("sweep_zo", {30'd0, bus.zero, bus.ovf}, {30'd0, e.z, e.o});
        end
        got++;
      end
      cyc++;
    end
    check("sweep_count", 32'(got), 32'd400);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
